match_event_counter: RTL
========================

# match_event_counter

Statistics stage directly downstream of the 1010 pattern detector. Consumes the detector's one-cycle match output `q` and keeps a saturating total match count and a per-window match count over fixed windows of `WIN_LEN` cycles. When a window closes with at least `THRESH` matches, it raises a level interrupt that is held until acknowledged.

## Interface
- `CNT_W`, 8: width of all count outputs; must satisfy 2^CNT_W > WIN_LEN.
- `WIN_LEN`, 16: window length in clock cycles, ≥ 2.
- `THRESH`, 4: minimum matches in one window that trigger `irq`, 1..WIN_LEN.

- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: synchronous, active-high.
- `det`  in  1: match strobe, driven by the detector's `q`.
- `ack`  in  1: interrupt acknowledge, one-cycle pulse.
- `total_cnt`  out  CNT_W: saturating count of qualified matches since reset.
- `win_cnt`  out  CNT_W: qualified matches so far in the current window.
- `win_last`  out  CNT_W: match count of the most recently closed window.
- `win_valid`  out  1: one-cycle pulse; `win_last` has just been updated.
- `irq`  out  1: threshold interrupt, level.
- `overflow`  out  1: sticky; `total_cnt` has saturated.
- `overrun`  out  1: sticky; a threshold event occurred while `irq` was already pending.

## Operation
- Qualified match (`hit`) is defined per the configuration below; it is sampled on every rising `clk` edge.
- total_cnt: increments by `hit` and stops at all-ones. A `hit` when the count is all-ones sets `overflow`.
- Window timer `cyc`: counts 0..WIN_LEN-1 and wraps to 0. The first window starts at the first edge after reset deasserts.
- Normal cycle (`cyc` ≠ WIN_LEN-1): `win_cnt += hit`.
- Close cycle (`cyc` = WIN_LEN-1):
  - `win_last <= win_cnt + hit`
  - `win_cnt <= 0`
  - `win_valid <= 1`
  - close event `trig = (win_cnt + hit ≥ THRESH)`
- IRQ FSM, two states:
  - IDLE, with `irq` = 0: goes to PEND on `trig`.
  - PEND, with `irq` = 1: goes to IDLE on `ack`.
  - `trig` and `ack` in the same cycle while in PEND: stays PEND; `overrun` is not set.
  - `trig` without `ack` while in PEND: stays PEND and sets `overrun`.
  - `ack` while in IDLE: ignored.
- `overflow` and `overrun` clear only on reset.

## Timing
- All outputs are registered; reset value of every output is 0, FSM resets to IDLE, `cyc` resets to 0.
- Latency from `det` to output, for a `det` sampled at edge N:
  - `total_cnt` and `win_cnt` reflect it after edge N.
  - On a close cycle, `win_last`, `win_valid` and `irq` change after edge N.
- `win_valid` is high for exactly one cycle per window: the cycle after each close edge.
- `irq` falls in the cycle after the edge that samples `ack`.
- Reset mid-window or mid-interrupt clears all state at that edge. A partial window is discarded and `irq` drops.
- Back-to-back detections (every 2 cycles, as overlapping 1010 produces) are all counted.

## Configuration
- `MATCH_EDGE_EN`:
  - Defined: `hit = det & ~det_q`, where `det_q` is `det` registered. Only rising edges count, so a detector held high counts once.
  - Undefined: `hit = det`; every high cycle counts. This is the default, correct for the one-cycle Moore strobe.

## Structure
- Package `match_stats_pkg`:
  - IRQ state enum (IDLE, PEND).
  - Default values of `CNT_W`, `WIN_LEN` and `THRESH`.
- Sub-module `win_timer`: the `cyc` counter.
  - Parameter `WIN_LEN`.
  - Ports `clk`, `reset`, and output `close` (high when `cyc` = WIN_LEN-1).
- The counters and IRQ FSM stay in the top module.

## Test plan
Defaults: CNT_W=8, WIN_LEN=16, THRESH=4; macro undefined unless stated.
- Reset held 5 cycles with `det`=1 → all outputs 0 throughout.
- `det` pulses at window cycles 2, 5, 9 → at close, `win_last`=3, `win_valid` pulses once, `total_cnt`=3, `irq` stays 0.
- `det` pulses at window cycles 1, 3, 5, 7, 15 (one on the close cycle) → `win_last`=5, `irq`=1 after close. `ack` pulse → `irq`=0 next cycle, `overrun`=0.
- Two consecutive windows of 6 matches each, no `ack` → `irq` stays 1, `overrun`=1 after the second close. `ack` coincident with a third close → `irq` stays 1.
- `det` held high 300 cycles → `total_cnt`=255, `overflow`=1, `win_last`=16 per window. With `MATCH_EDGE_EN` defined → `total_cnt`=1, `overflow`=0.
- Reset pulsed at window cycle 8 with `win_cnt`=3 and `irq`=1 → all outputs 0 next cycle; next `win_valid` arrives 16 cycles after reset deasserts.

Source files
------------

// File: rtl/match_stats_pkg.sv
// Shared types and default parameters for the match statistics stage.
package match_stats_pkg;
   typedef enum logic {IDLE = 1'b0, PEND = 1'b1} irq_state_t;

   localparam int DEF_CNT_W   = 8;
   localparam int DEF_WIN_LEN = 16;
   localparam int DEF_THRESH  = 4;
endpackage

// File: rtl/win_timer.sv
// Free-running window timer: cyc counts 0..WIN_LEN-1, close marks the last cycle.
module win_timer #(
   parameter int WIN_LEN = 16
) (
   input  logic clk,
   input  logic reset,
   output logic close
);
   localparam int CW = $clog2(WIN_LEN);
   localparam logic [CW-1:0] LAST = CW'(WIN_LEN - 1);

   logic [CW-1:0] cyc;

   always_ff @(posedge clk) begin
      if (reset)            cyc <= '0;
      else if (cyc == LAST) cyc <= '0;
      else                  cyc <= cyc + 1'b1;
   end

   assign close = (cyc == LAST);
endmodule

// File: rtl/match_event_counter.sv
// Match statistics: saturating total, per-window counts and threshold irq.
// Optional macro MATCH_EDGE_EN counts only rising edges of det.
module match_event_counter
   import match_stats_pkg::*;
#(
   parameter int CNT_W   = DEF_CNT_W,
   parameter int WIN_LEN = DEF_WIN_LEN,
   parameter int THRESH  = DEF_THRESH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             det,
   input  logic             ack,
   output logic [CNT_W-1:0] total_cnt,
   output logic [CNT_W-1:0] win_cnt,
   output logic [CNT_W-1:0] win_last,
   output logic             win_valid,
   output logic             irq,
   output logic             overflow,
   output logic             overrun
);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(THRESH);

   logic             hit;
   logic             close;
   logic             trig;
   logic [CNT_W-1:0] win_sum;
   irq_state_t       state;

`ifdef MATCH_EDGE_EN
   logic det_q;

   always_ff @(posedge clk) begin
      if (reset) det_q <= 1'b0;
      else       det_q <= det;
   end

   assign hit = det & ~det_q;
`else
   assign hit = det;
`endif

   win_timer #(.WIN_LEN(WIN_LEN)) u_win_timer (
      .clk   (clk),
      .reset (reset),
      .close (close)
   );

   // WIN_LEN < 2^CNT_W, so the window sum never wraps.
   assign win_sum = win_cnt + {{(CNT_W-1){1'b0}}, hit};
   assign trig    = close && (win_sum >= THRESH_C);

   always_ff @(posedge clk) begin
      if (reset) begin
         total_cnt <= '0;
         overflow  <= 1'b0;
      end else if (hit) begin
         if (total_cnt == CNT_MAX) overflow  <= 1'b1;
         else                      total_cnt <= total_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         win_cnt   <= '0;
         win_last  <= '0;
         win_valid <= 1'b0;
      end else if (close) begin
         win_last  <= win_sum;
         win_cnt   <= '0;
         win_valid <= 1'b1;
      end else begin
         win_cnt   <= win_sum;
         win_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         irq     <= 1'b0;
         overrun <= 1'b0;
      end else begin
         case (state)
            IDLE: if (trig) begin
               state <= PEND;
               irq   <= 1'b1;
            end
            PEND: begin
               // A fresh threshold event beats a same-cycle ack.
               if (ack && !trig) begin
                  state <= IDLE;
                  irq   <= 1'b0;
               end
               if (trig && !ack) overrun <= 1'b1;
            end
         endcase
      end
   end
endmodule
